// File: rtl/pid_bank_sequencer_pkg.sv
// Shared definitions for the PID bank sequencer: operand codes, ALU ops, FSM
// encoding and the fixed 10-instruction PID microprogram.
package pid_seq_pkg;

   localparam int NSTEPS = 10;

   localparam logic [3:0] REG_ZERO = 4'd0;
   localparam logic [3:0] REG_REF  = 4'd1;
   localparam logic [3:0] REG_POT  = 4'd2;
   localparam logic [3:0] REG_V1   = 4'd3;
   localparam logic [3:0] REG_A0   = 4'd4;
   localparam logic [3:0] REG_A1   = 4'd5;
   localparam logic [3:0] REG_A2   = 4'd6;
   localparam logic [3:0] REG_A3   = 4'd7;
   localparam logic [3:0] REG_T0   = 4'd8;
   localparam logic [3:0] REG_T1   = 4'd9;
   localparam logic [3:0] REG_T2   = 4'd10;

   localparam logic [2:0] ALU_PASS  = 3'd0;
   localparam logic [2:0] ALU_ADD   = 3'd1;
   localparam logic [2:0] ALU_SUB   = 3'd2;
   localparam logic [2:0] ALU_MULK0 = 3'd3;
   localparam logic [2:0] ALU_MULK1 = 3'd4;
   localparam logic [2:0] ALU_MULK2 = 3'd5;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_WRITE,
      ST_FIN
   } state_e;

   typedef struct packed {
      logic [2:0] op;
      logic [3:0] rd;
      logic [3:0] rt;
      logic [3:0] rs;
   } instr_t;

   // e = REF-POT; pk, ik, dk terms; pwm into t2; then shift ik and e history.
   function automatic instr_t prog_rom(input logic [3:0] idx);
      case (idx)
         4'd0:    prog_rom = '{ALU_SUB,   REG_V1, REG_REF, REG_POT };
         4'd1:    prog_rom = '{ALU_MULK0, REG_T1, REG_V1,  REG_ZERO};
         4'd2:    prog_rom = '{ALU_MULK1, REG_A3, REG_V1,  REG_ZERO};
         4'd3:    prog_rom = '{ALU_ADD,   REG_A0, REG_A2,  REG_A3  };
         4'd4:    prog_rom = '{ALU_SUB,   REG_A3, REG_V1,  REG_A1  };
         4'd5:    prog_rom = '{ALU_MULK2, REG_T0, REG_A3,  REG_ZERO};
         4'd6:    prog_rom = '{ALU_ADD,   REG_A3, REG_T1,  REG_A0  };
         4'd7:    prog_rom = '{ALU_ADD,   REG_T2, REG_A3,  REG_T0  };
         4'd8:    prog_rom = '{ALU_ADD,   REG_A2, REG_A0,  REG_ZERO};
         4'd9:    prog_rom = '{ALU_ADD,   REG_A1, REG_V1,  REG_ZERO};
         default: prog_rom = '0;
      endcase
   endfunction

endpackage

// File: rtl/pid_bank_sequencer_if.sv
// Control bundle between the sequencer (master) and the timer/bank/ALU side.
interface pid_bank_sequencer_if;
   logic       start;
   logic       hold;
   logic [3:0] RtAddrs;
   logic [3:0] RsAddrs;
   logic [3:0] RdAddrs;
   logic       WtReg;
   logic [2:0] AluOp;
   logic       busy;
   logic       done;
   logic [3:0] step;
   logic       overrun;

   modport master (
      input  start, hold,
      output RtAddrs, RsAddrs, RdAddrs, WtReg, AluOp, busy, done, step, overrun
   );

   modport slave (
      output start, hold,
      input  RtAddrs, RsAddrs, RdAddrs, WtReg, AluOp, busy, done, step, overrun
   );
endinterface

// File: rtl/pid_bank_sequencer_rom.sv
// Program table: step index to {AluOp, RdAddrs, RtAddrs, RsAddrs}.
module pid_seq_rom
   import pid_seq_pkg::*;
(
   input  logic [3:0] step_i,
   output instr_t     instr_o
);

   assign instr_o = prog_rom(step_i);

endmodule

// File: rtl/pid_bank_sequencer.sv
// Microprogram sequencer: walks the PID program once per sample tick, pacing
// each step by the ALU latency and pulsing the bank write at the end of it.
module pid_bank_sequencer
   import pid_seq_pkg::*;
#(
   parameter int unsigned ALU_LAT = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   pid_bank_sequencer_if.master bus
);

   localparam logic [3:0] LAT_M1 = (ALU_LAT == 0) ? 4'd0 : 4'(ALU_LAT - 1);
   localparam logic [3:0] LAST_STEP = 4'(NSTEPS - 1);

   state_e     state_q, state_d;
   logic [3:0] step_q, step_d;
   logic [3:0] cnt_q, cnt_d;
   logic       overrun_q, overrun_d;
   instr_t     instr;
   logic       in_step;

   pid_seq_rom u_rom (
      .step_i  (step_q),
      .instr_o (instr)
   );

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values, independent of block evaluation order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= ST_IDLE;
         step_q    <= '0;
         cnt_q     <= '0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         step_q    <= step_d;
         cnt_q     <= cnt_d;
         overrun_q <= overrun_d;
      end
   end

   // NOTE: every next-state signal gets a hold-value default first so no path
   // through the case leaves it unassigned and infers a latch.
   always_comb begin
      state_d   = state_q;
      step_d    = step_q;
      cnt_d     = cnt_q;
      overrun_d = overrun_q;

      // A tick arriving anywhere but IDLE is a missed sample; flag it even when held.
      if (bus.start && state_q != ST_IDLE) overrun_d = 1'b1;

      if (!bus.hold) begin
         case (state_q)
            ST_IDLE: begin
               if (bus.start) begin
                  state_d   = ST_ISSUE;
                  step_d    = '0;
                  overrun_d = 1'b0;
               end
            end
            ST_ISSUE: begin
               if (ALU_LAT == 0) begin
                  state_d = ST_WRITE;
               end else begin
                  state_d = ST_WAIT;
                  cnt_d   = LAT_M1;
               end
            end
            ST_WAIT: begin
               if (cnt_q == 4'd0) state_d = ST_WRITE;
               else               cnt_d   = cnt_q - 4'd1;
            end
            ST_WRITE: begin
               if (step_q == LAST_STEP) begin
                  state_d = ST_FIN;
               end else begin
                  state_d = ST_ISSUE;
                  step_d  = step_q + 4'd1;
               end
            end
            ST_FIN: begin
               state_d = ST_IDLE;
               step_d  = '0;
            end
            default: begin
               state_d = ST_IDLE;
               step_d  = '0;
               cnt_d   = '0;
            end
         endcase
      end
   end

   // Operand/op selects are only presented while a step is in flight.
   assign in_step     = (state_q == ST_ISSUE) || (state_q == ST_WAIT) || (state_q == ST_WRITE);
   assign bus.RtAddrs = in_step ? instr.rt : 4'd0;
   assign bus.RsAddrs = in_step ? instr.rs : 4'd0;
   assign bus.RdAddrs = in_step ? instr.rd : 4'd0;
   assign bus.AluOp   = in_step ? instr.op : 3'd0;
   assign bus.WtReg   = (state_q == ST_WRITE) && !bus.hold;
   assign bus.done    = (state_q == ST_FIN) && !bus.hold;
   assign bus.busy    = (state_q != ST_IDLE);
   assign bus.step    = step_q;
   assign bus.overrun = overrun_q;

endmodule

// File: tb/tb_pid_bank_sequencer.sv
// Scoreboard bench: expected write/done events are queued at each start and
// matched against the DUT's WtReg/done pulses; also covers latency extremes.
module tb_pid_bank_sequencer;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   pid_bank_sequencer_if u2 ();
   pid_bank_sequencer_if u0 ();
   pid_bank_sequencer_if u15 ();

   pid_bank_sequencer #(.ALU_LAT(2))  dut2  (.clk(clk), .rst(rst), .bus(u2));
   pid_bank_sequencer #(.ALU_LAT(0))  dut0  (.clk(clk), .rst(rst), .bus(u0));
   pid_bank_sequencer #(.ALU_LAT(15)) dut15 (.clk(clk), .rst(rst), .bus(u15));

   int checks   = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   typedef struct {
      int cyc;
      int rd;
   } wr_t;

   wr_t wr_q[$];
   int  done_q[$];
   int  rd_seq[10] = '{3, 9, 7, 4, 7, 8, 7, 10, 6, 5};

   int pcnt = 0;
   int base = 0;
   bit mon_en = 1'b0;
   always @(posedge clk) pcnt <= pcnt + 1;

   // Queue expected writes at (LAT+2)*(k+1) for LAT=2; steps >= shift_from slip by shift.
   task automatic push_run(input int nwr, input int shift_from, input int shift, input bit with_done);
      for (int k = 0; k < nwr; k++) begin
         wr_t e;
         e.cyc = 4 * (k + 1) + ((k >= shift_from) ? shift : 0);
         e.rd  = rd_seq[k];
         wr_q.push_back(e);
      end
      if (with_done) done_q.push_back(41 + shift);
   endtask

   always @(negedge clk) begin
      int  rel;
      wr_t e;
      int  dc;
      if (mon_en) begin
         rel = pcnt - base;
         if (u2.WtReg === 1'b1) begin
            if (wr_q.size() == 0) check("wr_unexpected_cycle", rel, -1);
            else begin
               e = wr_q.pop_front();
               check("wr_cycle", rel, e.cyc);
               check("wr_rd", u2.RdAddrs, e.rd);
            end
         end
         if (u2.done === 1'b1) begin
            if (done_q.size() == 0) check("done_unexpected_cycle", rel, -1);
            else begin
               dc = done_q.pop_front();
               check("done_cycle", rel, dc);
            end
         end
      end
   end

   task automatic kick();
      @(negedge clk);
      u2.start = 1'b1;
      base = pcnt;
   endtask

   task automatic drain(input string tag);
      check({tag, "_wr_left"}, wr_q.size(), 0);
      check({tag, "_done_left"}, done_q.size(), 0);
   endtask

   initial begin
      int d0, d15, f0, f15, n0, n15;
      u2.start = 1'b0;  u2.hold = 1'b0;
      u0.start = 1'b0;  u0.hold = 1'b0;
      u15.start = 1'b0; u15.hold = 1'b0;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_busy", u2.busy, 0);
      check("rst_wt", u2.WtReg, 0);
      check("rst_done", u2.done, 0);
      check("rst_step", u2.step, 0);
      check("rst_ovr", u2.overrun, 0);
      check("rst_rt", u2.RtAddrs, 0);
      check("rst_op", u2.AluOp, 0);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      check("idle_busy", u2.busy, 0);
      mon_en = 1'b1;

      // Run A: nominal run, step 0 detail, overrun on start at cycle 10
      push_run(10, 0, 0, 1'b1);
      kick();
      for (int c = 1; c <= 45; c++) begin
         @(negedge clk);
         if (c == 1) begin
            u2.start = 1'b0;
            check("a_busy_c1", u2.busy, 1);
            check("a_ovr_c1", u2.overrun, 0);
         end
         if (c <= 4) begin
            check("a_s0_rt", u2.RtAddrs, 1);
            check("a_s0_rs", u2.RsAddrs, 2);
            check("a_s0_rd", u2.RdAddrs, 3);
            check("a_s0_op", u2.AluOp, 2);
         end
         if (c == 10) u2.start = 1'b1;
         if (c == 11) begin
            u2.start = 1'b0;
            check("a_ovr_set", u2.overrun, 1);
         end
         if (c == 41) check("a_busy_c41", u2.busy, 1);
         if (c == 42) begin
            check("a_busy_c42", u2.busy, 0);
            check("a_ovr_sticky", u2.overrun, 1);
         end
      end
      drain("a");

      // Run B: hold over cycles 7..12 delays step 1's write and done by 6
      push_run(10, 1, 6, 1'b1);
      kick();
      for (int c = 1; c <= 52; c++) begin
         @(negedge clk);
         if (c == 1) begin
            u2.start = 1'b0;
            check("b_ovr_cleared", u2.overrun, 0);
         end
         if (c == 7) u2.hold = 1'b1;
         if (c == 10) check("b_hold_step", u2.step, 1);
         if (c == 13) u2.hold = 1'b0;
      end
      drain("b");

      // Run C: async reset in the WAIT of step 5, with overrun set beforehand
      push_run(5, 0, 0, 1'b0);
      kick();
      for (int c = 1; c <= 22; c++) begin
         @(negedge clk);
         if (c == 1) u2.start = 1'b0;
         if (c == 12) u2.start = 1'b1;
         if (c == 13) u2.start = 1'b0;
      end
      check("c_step_pre", u2.step, 5);
      check("c_busy_pre", u2.busy, 1);
      rst = 1'b0;
      #1;
      check("c_rst_busy", u2.busy, 0);
      check("c_rst_step", u2.step, 0);
      check("c_rst_rt", u2.RtAddrs, 0);
      check("c_rst_rd", u2.RdAddrs, 0);
      check("c_rst_op", u2.AluOp, 0);
      check("c_rst_ovr", u2.overrun, 0);
      @(negedge clk);
      rst = 1'b1;
      repeat (8) @(negedge clk);
      check("c_post_busy", u2.busy, 0);
      drain("c");

      // Run D: after reset the program restarts from step 0
      push_run(10, 0, 0, 1'b1);
      kick();
      for (int c = 1; c <= 45; c++) begin
         @(negedge clk);
         if (c == 1) begin
            u2.start = 1'b0;
            check("d_step_c1", u2.step, 0);
            check("d_rt_c1", u2.RtAddrs, 1);
         end
      end
      drain("d");

      // Latency extremes: ALU_LAT=0 and ALU_LAT=15
      d0 = -1; d15 = -1; f0 = -1; f15 = -1; n0 = 0; n15 = 0;
      @(negedge clk);
      u0.start = 1'b1;
      u15.start = 1'b1;
      for (int c = 1; c <= 185; c++) begin
         @(negedge clk);
         if (c == 1) begin
            u0.start = 1'b0;
            u15.start = 1'b0;
         end
         if (u0.WtReg === 1'b1) begin
            n0++;
            if (f0 < 0) f0 = c;
         end
         if (u15.WtReg === 1'b1) begin
            n15++;
            if (f15 < 0) f15 = c;
         end
         if (u0.done === 1'b1 && d0 < 0) d0 = c;
         if (u15.done === 1'b1 && d15 < 0) d15 = c;
      end
      check("lat0_first_wr", f0, 2);
      check("lat0_writes", n0, 10);
      check("lat0_done", d0, 21);
      check("lat15_first_wr", f15, 17);
      check("lat15_writes", n15, 10);
      check("lat15_done", d15, 171);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
